gnn_host_if: RTL and testbench

Host-side driver and collector for the 4-node GNN compute top. It accepts a serial stream of 5-bit signed operands (16 node features, then 24 weights) and assembles them into the parallel operand bus the compute top consumes. It then raises `in_ready`, captures the eight 21-bit results as their per-output ready flags assert, and drains them as a valid/ready output stream. It sits between a host/DMA port and the compute top, replacing direct testbench driving of the top's pins.

---
 rtl/gnn_host_if.sv | 138 +++++++++++++
 tb/tb_gnn_host_if.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_host_if.sv
// Host-side operand loader and result collector for the 4-node GNN compute top.
// Streams in 40 operands, issues them, captures 8 results by ready flag, drains them as a stream.
module gnn_host_if #(
    parameter int unsigned N_X     = 16,
    parameter int unsigned N_W     = 24,
    parameter int unsigned N_OUT   = 8,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [4:0]             s_data,
    output logic [5*N_X-1:0]       x_flat,
    output logic [5*N_W-1:0]       w_flat,
    output logic                   in_ready,
    input  logic [21*N_OUT-1:0]    out_flat,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [20:0]            m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int unsigned OW   = 5;
    localparam int unsigned RW   = 21;
    localparam int unsigned N_OP = N_X + N_W;
    localparam int unsigned LD_W = $clog2(N_OP);
    localparam int unsigned WT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DR_W = $clog2(N_OUT);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

    state_t            state;
    logic [LD_W-1:0]   ld_cnt;
    logic [WT_W-1:0]   wait_cnt;
    logic [DR_W-1:0]   dr_idx;
    logic [DR_W-1:0]   dr_nxt;
    logic [N_OUT-1:0]  mask;
    logic [RW-1:0]     cap [N_OUT];
    logic              s_fire;
    logic              m_fire;

    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;
    assign dr_nxt = dr_idx + DR_W'(1);

    // Single-process FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            ld_cnt      <= '0;
            wait_cnt    <= '0;
            dr_idx      <= '0;
            mask        <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) cap[j] <= '0;
            x_flat      <= '0;
            w_flat      <= '0;
            s_ready     <= 1'b0;
            in_ready    <= 1'b0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_data      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (s_fire) begin
                        for (int unsigned k = 0; k < N_X; k++)
                            if (ld_cnt == LD_W'(k)) x_flat[OW*k +: OW] <= s_data;
                        for (int unsigned k = 0; k < N_W; k++)
                            if (ld_cnt == LD_W'(N_X + k)) w_flat[OW*k +: OW] <= s_data;
                        if (ld_cnt == LD_W'(N_OP - 1)) begin
                            // Last operand: issue, and start the timeout window from this edge.
                            state    <= ISSUE;
                            ld_cnt   <= '0;
                            s_ready  <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            mask     <= '0;
                            wait_cnt <= '0;
                            for (int unsigned j = 0; j < N_OUT; j++) cap[j] <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + LD_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= wait_cnt + WT_W'(1);
                end
                WAIT: begin
                    if ((&mask) || (wait_cnt == WT_W'(TIMEOUT))) begin
                        if (!(&mask)) err_timeout <= 1'b1;
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                        m_valid  <= 1'b1;
                        m_data   <= cap[0];
                        m_last   <= 1'b0;
                        dr_idx   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WT_W'(1);
                        // First ready wins; later changes of a captured word are ignored.
                        for (int unsigned j = 0; j < N_OUT; j++) begin
                            if (out_ready[j] && !mask[j]) begin
                                cap[j]  <= out_flat[RW*j +: RW];
                                mask[j] <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (m_fire) begin
                        if (dr_idx == DR_W'(N_OUT - 1)) begin
                            state   <= LOAD;
                            dr_idx  <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_data  <= '0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            dr_idx <= dr_nxt;
                            m_data <= cap[dr_nxt];
                            m_last <= (dr_nxt == DR_W'(N_OUT - 1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_host_if.sv
// Directed bench for gnn_host_if; a behavioural 4-node ring GNN stands in for the compute top.
`timescale 1ns/1ps
module tb_gnn_host_if;

    localparam int TIMEOUT = 63;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [4:0]   s_data = '0;
    logic [79:0]  x_flat;
    logic [119:0] w_flat;
    logic         in_ready;
    logic [167:0] out_flat = '0;
    logic [7:0]   out_ready = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [20:0]  m_data;
    logic         m_last;
    logic         busy;
    logic         err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_issue = 0;
    logic [4:0] ops [40];
    int exp_beats [8];

    gnn_host_if #(.N_X(16), .N_W(24), .N_OUT(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .x_flat(x_flat), .w_flat(w_flat), .in_ready(in_ready),
        .out_flat(out_flat), .out_ready(out_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [167:0] got, input logic [167:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int sx(input int k);
        return int'($signed(ops[k]));
    endfunction

    // Ring aggregation (self + both neighbours) each layer, ReLU between layers.
    function automatic logic [167:0] model();
        int a [4][4];
        int h [4][4];
        int acc;
        logic [167:0] r;
        r = '0;
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 4; i++)
                a[n][i] = sx(4*n+i) + sx(4*((n+3)%4)+i) + sx(4*((n+1)%4)+i);
        for (int n = 0; n < 4; n++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int i = 0; i < 4; i++) acc += a[n][i] * sx(16 + 4*j + i);
                h[n][j] = (acc < 0) ? 0 : acc;
            end
        for (int n = 0; n < 4; n++)
            for (int k = 0; k < 2; k++) begin
                acc = 0;
                for (int j = 0; j < 4; j++)
                    acc += (h[(n+3)%4][j] + h[n][j] + h[(n+1)%4][j]) * sx(32 + 4*k + j);
                r[21*(2*n+k) +: 21] = 21'(acc);
            end
        return r;
    endfunction

    function automatic logic [79:0] pack_x();
        logic [79:0] r;
        for (int k = 0; k < 16; k++) r[5*k +: 5] = ops[k];
        return r;
    endfunction

    function automatic logic [119:0] pack_w();
        logic [119:0] r;
        for (int k = 0; k < 24; k++) r[5*k +: 5] = ops[16+k];
        return r;
    endfunction

    task automatic fill_all(input int v);
        for (int k = 0; k < 40; k++) ops[k] = 5'(v);
    endtask

    task automatic fill_mixed();
        int m [40] = '{4, 2, 4, 1,   6, 4, 4, 1,   8, 6, 4, 1,   6, 4, 4, 1,
                       3, 2, 13, -6,  -9, 1, -4, 14,  3, 6, -15, 15,  9, -10, 15, -10,
                       0, -1, 3, -11,  -12, -15, -15, 6};
        for (int k = 0; k < 40; k++) ops[k] = 5'(m[k]);
    endtask

    task automatic set_exp_all(input int v);
        for (int b = 0; b < 8; b++) exp_beats[b] = v;
    endtask

    task automatic set_exp_mixed();
        int e [8] = '{-6358, -4188, -6309, -4455, -6287, -4587, -6309, -4455};
        for (int b = 0; b < 8; b++) exp_beats[b] = e[b];
    endtask

    // Drive n_beats operands from ops[], optionally with random idle gaps.
    task automatic load(input int n_beats, input int gap_max);
        int b;
        for (int k = 0; k < n_beats; k++) begin
            if (gap_max > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = ops[k];
            b = 0;
            @(negedge clk);
            while (!s_ready && b < 200) begin
                @(negedge clk);
                b++;
            end
            if (!s_ready) begin
                chk("s_ready_wait", s_ready, 1'b1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        t_issue = cyc;
    endtask

    // Act as compute top, then collect and check the 8 result beats.
    task automatic run_results(input logic [7:0] rmask, input bit stall, input bit exp_err, input int exp_lat);
        logic [167:0] res;
        logic [20:0]  prev;
        logic [20:0]  want;
        bit           prev_stall;
        int           b;
        int           beats;
        res = model();
        chk("in_ready_issue", in_ready, 1'b1);
        chk("busy_issue", busy, 1'b1);
        chk("s_ready_issue", s_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        out_flat  = res;
        out_ready = rmask & 8'h0F;
        @(posedge clk);
        #1;
        out_flat  = res ^ {84'h0, {84{1'b1}}};
        out_ready = rmask;
        b = 0;
        while (!m_valid && b < 200) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("m_valid_rise", m_valid, 1'b1);
        chk("in_ready_fall", in_ready, 1'b0);
        chk("err_timeout", err_timeout, exp_err);
        if (exp_lat >= 0) chk("timeout_latency", 32'(cyc - t_issue), 32'(exp_lat));
        out_ready = '0;
        out_flat  = '0;
        beats = 0;
        b = 0;
        prev_stall = 1'b0;
        prev = '0;
        while (beats < 8 && b < 300) begin
            m_ready = stall ? ($urandom_range(2, 0) == 0) : 1'b1;
            @(negedge clk);
            if (m_valid && prev_stall) chk("stall_hold", m_data, prev);
            if (m_valid && m_ready) begin
                want = 21'(exp_beats[beats]);
                chk($sformatf("beat%0d_data", beats), m_data, want);
                chk($sformatf("beat%0d_last", beats), m_last, (beats == 7));
                beats++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_valid;
                prev = m_data;
            end
            @(posedge clk);
            #1;
            b++;
        end
        m_ready = 1'b0;
        chk("beat_count", 32'(beats), 32'd8);
        chk("m_valid_end", m_valid, 1'b0);
        chk("busy_end", busy, 1'b0);
    endtask

    initial begin
        logic [79:0] neg_x;
        neg_x = {16{5'b10000}};
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 21'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_x_flat", x_flat, 80'd0);
        chk("rst_w_flat", w_flat, 120'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", s_ready, 1'b1);

        fill_all(15);
        set_exp_all(486000);
        load(40, 0);
        run_results(8'hFF, 1'b0, 1'b0, -1);

        fill_all(-16);
        set_exp_all(-589824);
        load(40, 0);
        chk("x_flat_neg16", x_flat, neg_x);
        run_results(8'hFF, 1'b0, 1'b0, -1);

        fill_mixed();
        set_exp_mixed();
        load(40, 0);
        chk("x_flat_mixed", x_flat, pack_x());
        chk("w_flat_mixed", w_flat, pack_w());
        run_results(8'hFF, 1'b0, 1'b0, -1);

        load(40, 3);
        chk("w_flat_gaps", w_flat, pack_w());
        run_results(8'hFF, 1'b1, 1'b0, -1);

        fill_all(15);
        set_exp_all(486000);
        load(20, 0);
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_x_flat", x_flat, 80'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load(40, 0);
        run_results(8'hFF, 1'b0, 1'b0, -1);

        exp_beats[5] = 0;
        load(40, 0);
        chk("err_before_timeout", err_timeout, 1'b0);
        run_results(8'hDF, 1'b0, 1'b1, TIMEOUT + 1);

        fill_all(-16);
        set_exp_all(-589824);
        load(40, 0);
        chk("err_sticky", err_timeout, 1'b1);
        run_results(8'hFF, 1'b0, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
